// File: rtl/bram_word_bridge_pkg.sv
// ----------------------------------------------------------------------------
// rsa_pkg
//   Shared sizing constants and the TX state encoding for the word/chunk
//   width-conversion bridge.
//
//   RSA_BITS   : chunk width seen by the Montgomery command wrapper
//   WORD_BITS  : stream word width on the DMA/ARM side
//   WORDS      : number of stream words per chunk
//   IDX_BITS   : width of a word index inside a chunk
//   LAST_IDX   : index of the final (most-significant) word of a chunk
//   tx_state_e : states of the TX unpacker FSM
// ----------------------------------------------------------------------------
package rsa_pkg;

   localparam int RSA_BITS  = 1024;
   localparam int WORD_BITS = 32;
   localparam int WORDS     = RSA_BITS / WORD_BITS;
   localparam int IDX_BITS  = $clog2(WORDS);

   localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(WORDS - 1);

   // TX_WAIT_LOW holds off a new capture until the wrapper has dropped its
   // registered valid after seeing the read pulse.
   typedef enum logic [1:0] {
      TX_IDLE     = 2'd0,
      TX_SEND     = 2'd1,
      TX_ACK      = 2'd2,
      TX_WAIT_LOW = 2'd3
   } tx_state_e;

endpackage : rsa_pkg

// File: rtl/bram_word_bridge_if.sv
// ----------------------------------------------------------------------------
// bram_word_bridge_if
//   Bundles the three handshakes around the bridge:
//     s_wdata/s_wvalid/s_wready      : upstream 32-bit word stream (RX)
//     bram_din/bram_din_valid        : packed chunk towards the wrapper
//     bram_dout/bram_dout_valid/
//     bram_dout_read                 : result chunk from the wrapper
//     m_rdata/m_rvalid/m_rready      : downstream 32-bit word stream (TX)
//
//   slave  : the view taken by the bridge itself
//   master : the view taken by whatever surrounds the bridge
// ----------------------------------------------------------------------------
interface bram_word_bridge_if;
   import rsa_pkg::*;

   logic [WORD_BITS-1:0] s_wdata;
   logic                 s_wvalid;
   logic                 s_wready;

   logic [RSA_BITS-1:0]  bram_din;
   logic                 bram_din_valid;

   logic [RSA_BITS-1:0]  bram_dout;
   logic                 bram_dout_valid;
   logic                 bram_dout_read;

   logic [WORD_BITS-1:0] m_rdata;
   logic                 m_rvalid;
   logic                 m_rready;

   modport slave (
      input  s_wdata,
      input  s_wvalid,
      output s_wready,
      output bram_din,
      output bram_din_valid,
      input  bram_dout,
      input  bram_dout_valid,
      output bram_dout_read,
      output m_rdata,
      output m_rvalid,
      input  m_rready
   );

   modport master (
      output s_wdata,
      output s_wvalid,
      input  s_wready,
      input  bram_din,
      input  bram_din_valid,
      output bram_dout,
      output bram_dout_valid,
      input  bram_dout_read,
      input  m_rdata,
      input  m_rvalid,
      output m_rready
   );

endinterface : bram_word_bridge_if

// File: rtl/bram_word_bridge_word_unpacker.sv
// ----------------------------------------------------------------------------
// word_unpacker
//   TX half of the bridge. Captures one chunk offered by the wrapper, streams
//   it out least-significant word first, then acknowledges it with a single
//   read pulse.
//
//   clk, resetn      : clock, asynchronous active-low reset
//   bram_dout        : chunk from the wrapper (sampled only at capture)
//   bram_dout_valid  : wrapper offers a chunk (level)
//   bram_dout_read   : one-cycle pulse once all words have been sent
//   m_rdata          : current downstream word
//   m_rvalid         : downstream word valid
//   m_rready         : downstream accepts the word
// ----------------------------------------------------------------------------
module word_unpacker
   import rsa_pkg::*;
(
   input  logic                 clk,
   input  logic                 resetn,
   input  logic [RSA_BITS-1:0]  bram_dout,
   input  logic                 bram_dout_valid,
   output logic                 bram_dout_read,
   output logic [WORD_BITS-1:0] m_rdata,
   output logic                 m_rvalid,
   input  logic                 m_rready
);

   tx_state_e             state_q, state_d;
   logic [RSA_BITS-1:0]   shift_q, shift_d;
   logic [IDX_BITS-1:0]   tx_idx_q, tx_idx_d;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= TX_IDLE;
         shift_q  <= '0;
         tx_idx_q <= '0;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         tx_idx_q <= tx_idx_d;
      end
   end

   // The outgoing word is always the low slice of the shift register, so it
   // stays put for as long as the downstream side stalls.
   always_comb begin
      state_d        = state_q;
      shift_d        = shift_q;
      tx_idx_d       = tx_idx_q;
      m_rvalid       = 1'b0;
      bram_dout_read = 1'b0;
      m_rdata        = shift_q[WORD_BITS-1:0];

      case (state_q)
         TX_IDLE: begin
            if (bram_dout_valid) begin
               shift_d  = bram_dout;
               tx_idx_d = '0;
               state_d  = TX_SEND;
            end
         end

         TX_SEND: begin
            m_rvalid = 1'b1;
            if (m_rready) begin
               shift_d  = shift_q >> WORD_BITS;
               tx_idx_d = tx_idx_q + 1'b1;
               if (tx_idx_q == LAST_IDX) begin
                  state_d = TX_ACK;
               end
            end
         end

         TX_ACK: begin
            bram_dout_read = 1'b1;
            state_d        = TX_WAIT_LOW;
         end

         TX_WAIT_LOW: begin
            // The wrapper's valid is still high for the cycle after the read
            // pulse; recapturing here would replay the same chunk.
            if (!bram_dout_valid) begin
               state_d = TX_IDLE;
            end
         end

         default: begin
            state_d = TX_IDLE;
         end
      endcase
   end

endmodule : word_unpacker

// File: rtl/bram_word_bridge.sv
// ----------------------------------------------------------------------------
// bram_word_bridge
//   Width conversion between a 32-bit word stream and 1024-bit chunk ports.
//   RX packs 32 consecutive upstream words into bram_din and pulses
//   bram_din_valid; TX (word_unpacker) streams a captured bram_dout chunk out
//   as 32 words. The two directions are fully independent.
//
//   clk    : single clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : bram_word_bridge_if.slave carrying all stream and chunk signals
// ----------------------------------------------------------------------------
module bram_word_bridge
   import rsa_pkg::*;
(
   input  logic                     clk,
   input  logic                     resetn,
   bram_word_bridge_if.slave        bus
);

   logic                  s_wready_q, s_wready_d;
   logic [IDX_BITS-1:0]   rx_idx_q, rx_idx_d;
   logic [RSA_BITS-1:0]   bram_din_q, bram_din_d;
   logic                  din_valid_q, din_valid_d;
   logic                  rx_accept;

   // Ready is registered so that it reads 0 during reset and rises on the
   // first clock edge after reset is released.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s_wready_q  <= 1'b0;
         rx_idx_q    <= '0;
         bram_din_q  <= '0;
         din_valid_q <= 1'b0;
      end else begin
         s_wready_q  <= s_wready_d;
         rx_idx_q    <= rx_idx_d;
         bram_din_q  <= bram_din_d;
         din_valid_q <= din_valid_d;
      end
   end

   assign rx_accept = bus.s_wvalid & s_wready_q;

   // Each accepted word lands in its own slice; untouched slices keep the
   // previous chunk, so the wrapper has to sample bram_din in the pulse cycle.
   always_comb begin
      s_wready_d  = 1'b1;
      rx_idx_d    = rx_idx_q;
      bram_din_d  = bram_din_q;
      din_valid_d = 1'b0;

      if (rx_accept) begin
         bram_din_d[rx_idx_q*WORD_BITS +: WORD_BITS] = bus.s_wdata;
         if (rx_idx_q == LAST_IDX) begin
            rx_idx_d    = '0;
            din_valid_d = 1'b1;
         end else begin
            rx_idx_d    = rx_idx_q + 1'b1;
         end
      end
   end

   assign bus.s_wready       = s_wready_q;
   assign bus.bram_din       = bram_din_q;
   assign bus.bram_din_valid = din_valid_q;

   word_unpacker u_word_unpacker (
      .clk             (clk),
      .resetn          (resetn),
      .bram_dout       (bus.bram_dout),
      .bram_dout_valid (bus.bram_dout_valid),
      .bram_dout_read  (bus.bram_dout_read),
      .m_rdata         (bus.m_rdata),
      .m_rvalid        (bus.m_rvalid),
      .m_rready        (bus.m_rready)
   );

endmodule : bram_word_bridge

// File: tb/tb_bram_word_bridge.sv
// ----------------------------------------------------------------------------
// tb_bram_word_bridge
//   Self-checking bench for bram_word_bridge. Expected chunks and words are
//   built by the bench and queued when stimulus is driven; negedge monitors
//   pop and compare them as the bridge produces output.
// ----------------------------------------------------------------------------
module tb_bram_word_bridge;
   import rsa_pkg::*;

   logic clk;
   logic resetn;

   bram_word_bridge_if bus ();

   bram_word_bridge dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int rd_cnt = 0;
   int din_cnt = 0;
   int tx_pop_cnt = 0;

   logic [31:0]   txq[$];
   logic [1023:0] rxq[$];

   typedef struct {
      logic [31:0] base;
      logic [31:0] stride;
      logic        gaps;
      int          exp_pulses;
   } rx_vec_t;

   typedef struct {
      logic [31:0] key;
      int          stall_at;
      int          stall_len;
      logic        drop_valid;
      int          exp_words;
      int          exp_reads;
   } tx_vec_t;

   rx_vec_t rx_tab[3];
   tx_vec_t tx_tab[3];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_chunk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic report_fail(input string name);
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL %s: got unexpected event expected none", name);
   endtask

   function automatic logic [1023:0] rx_chunk(input logic [31:0] base, input logic [31:0] stride);
      logic [1023:0] c;
      for (int k = 0; k < WORDS; k++) c[k*32 +: 32] = base + 32'(k) * stride;
      return c;
   endfunction

   function automatic logic [1023:0] tx_chunk(input logic [31:0] key);
      logic [1023:0] c;
      for (int k = 0; k < WORDS; k++) c[k*32 +: 32] = 32'hA5A5_A5A5 ^ (32'(k) * key);
      return c;
   endfunction

   // Output monitors: sampled on the falling edge, half a cycle from the
   // edges where inputs change and the design updates.
   always @(negedge clk) begin
      if (resetn) begin
         if (bus.m_rvalid && bus.m_rready) begin
            if (txq.size() == 0) report_fail("tx_unexpected_word");
            else begin
               tx_pop_cnt++;
               check_output("tx_word", bus.m_rdata, txq.pop_front());
            end
         end
         if (bus.bram_din_valid) begin
            din_cnt++;
            if (rxq.size() == 0) report_fail("rx_unexpected_pulse");
            else check_chunk("rx_chunk", bus.bram_din, rxq.pop_front());
         end
         if (bus.bram_dout_read) rd_cnt++;
      end
   end

   task automatic apply_rx(input logic [31:0] base, input logic [31:0] stride, input logic gaps);
      logic [1023:0] exp;
      exp = rx_chunk(base, stride);
      for (int k = 0; k < WORDS; k++) begin
         bus.s_wvalid = 1'b1;
         bus.s_wdata  = base + 32'(k) * stride;
         if (k == WORDS - 1) rxq.push_back(exp);
         step();
         if (gaps && k < WORDS - 1) begin
            bus.s_wvalid = 1'b0;
            bus.s_wdata  = 32'hDEAD_BEEF;
            step();
            check_output("rx_no_early_pulse", 32'(bus.bram_din_valid), 32'd0);
         end
      end
      bus.s_wvalid = 1'b0;
      check_output("rx_pulse_latency", 32'(bus.bram_din_valid), 32'd1);
      step();
      check_output("rx_pulse_width", 32'(bus.bram_din_valid), 32'd0);
   endtask

   task automatic apply_tx(input logic [31:0] key, input int stall_at, input int stall_len, input logic drop_valid);
      logic [1023:0] c;
      int sent;
      int guard;
      int rd0;
      int stl;
      c     = tx_chunk(key);
      sent  = 0;
      guard = 0;
      rd0   = rd_cnt;
      stl   = stall_len;
      for (int k = 0; k < WORDS; k++) txq.push_back(c[k*32 +: 32]);
      bus.bram_dout       = c;
      bus.bram_dout_valid = 1'b1;
      bus.m_rready        = 1'b1;
      step();
      check_output("tx_first_valid", 32'(bus.m_rvalid), 32'd1);
      bus.bram_dout = ~c;
      while (sent < WORDS && guard < 500) begin
         if (sent == stall_at && stl > 0 && bus.m_rvalid) begin
            bus.m_rready = 1'b0;
            for (int s = 0; s < stl; s++) begin
               step();
               check_output("tx_stall_data", bus.m_rdata, c[stall_at*32 +: 32]);
               check_output("tx_stall_valid", 32'(bus.m_rvalid), 32'd1);
            end
            bus.m_rready = 1'b1;
            stl = 0;
         end
         if (drop_valid && sent == 4) bus.bram_dout_valid = 1'b0;
         if (bus.m_rvalid && bus.m_rready) sent++;
         step();
         guard++;
      end
      if (guard >= 500) report_fail("tx_timeout");
      check_output("tx_ack_pulse", 32'(bus.bram_dout_read), 32'd1);
      check_output("tx_ack_no_valid", 32'(bus.m_rvalid), 32'd0);
      step();
      check_output("tx_ack_width", 32'(bus.bram_dout_read), 32'd0);
      bus.bram_dout_valid = 1'b0;
      step();
      step();
      step();
      check_output("tx_no_recapture", 32'(bus.m_rvalid), 32'd0);
      check_output("tx_read_count", 32'(rd_cnt - rd0), 32'd1);
   endtask

   initial begin
      rx_tab[0] = '{base: 32'h0, stride: 32'h1, gaps: 1'b0, exp_pulses: 1};
      rx_tab[1] = '{base: 32'h0, stride: 32'h1, gaps: 1'b1, exp_pulses: 1};
      rx_tab[2] = '{base: 32'h1234_0000, stride: 32'h0101_0101, gaps: 1'b0, exp_pulses: 1};
      tx_tab[0] = '{key: 32'h1, stall_at: -1, stall_len: 0, drop_valid: 1'b0, exp_words: 32, exp_reads: 1};
      tx_tab[1] = '{key: 32'h1, stall_at: 7, stall_len: 5, drop_valid: 1'b0, exp_words: 32, exp_reads: 1};
      tx_tab[2] = '{key: 32'h0003_1000, stall_at: -1, stall_len: 0, drop_valid: 1'b1, exp_words: 32, exp_reads: 1};

      resetn              = 1'b0;
      bus.s_wdata         = '0;
      bus.s_wvalid        = 1'b0;
      bus.bram_dout       = '0;
      bus.bram_dout_valid = 1'b0;
      bus.m_rready        = 1'b0;
      #1;
      check_output("rst_s_wready", 32'(bus.s_wready), 32'd0);
      check_chunk("rst_bram_din", bus.bram_din, '0);
      check_output("rst_din_valid", 32'(bus.bram_din_valid), 32'd0);
      check_output("rst_m_rvalid", 32'(bus.m_rvalid), 32'd0);
      check_output("rst_read", 32'(bus.bram_dout_read), 32'd0);
      step();
      step();
      resetn = 1'b1;
      check_output("rst_release_ready_low", 32'(bus.s_wready), 32'd0);
      step();
      check_output("ready_after_reset", 32'(bus.s_wready), 32'd1);

      $display("[TB] RX table");
      for (int i = 0; i < 3; i++) begin
         int d0;
         d0 = din_cnt;
         apply_rx(rx_tab[i].base, rx_tab[i].stride, rx_tab[i].gaps);
         step();
         check_output("rx_pulse_count", 32'(din_cnt - d0), 32'(rx_tab[i].exp_pulses));
      end
      check_output("rx_first_word", bus.bram_din[31:0], 32'h1234_0000);

      $display("[TB] TX table");
      for (int i = 0; i < 3; i++) begin
         int p0;
         int r0;
         p0 = tx_pop_cnt;
         r0 = rd_cnt;
         apply_tx(tx_tab[i].key, tx_tab[i].stall_at, tx_tab[i].stall_len, tx_tab[i].drop_valid);
         check_output("tx_word_count", 32'(tx_pop_cnt - p0), 32'(tx_tab[i].exp_words));
         check_output("tx_reads_total", 32'(rd_cnt - r0), 32'(tx_tab[i].exp_reads));
      end

      $display("[TB] concurrent RX and TX");
      fork
         apply_rx(32'hCAFE_0000, 32'h0000_0011, 1'b0);
         apply_tx(32'h0000_0777, 3, 2, 1'b0);
      join
      check_output("conc_rx_queue_empty", 32'(rxq.size()), 32'd0);
      check_output("conc_tx_queue_empty", 32'(txq.size()), 32'd0);

      $display("[TB] reset mid-operation");
      begin
         logic [1023:0] c;
         c = tx_chunk(32'h55);
         for (int k = 0; k < WORDS; k++) txq.push_back(c[k*32 +: 32]);
         bus.bram_dout       = c;
         bus.bram_dout_valid = 1'b1;
         bus.m_rready        = 1'b1;
         for (int k = 0; k < 12; k++) begin
            bus.s_wvalid = (k < 11);
            bus.s_wdata  = 32'h7700_0000 + 32'(k);
            step();
         end
         bus.s_wvalid = 1'b0;
         check_output("mid_tx_active", 32'(bus.m_rvalid), 32'd1);
         resetn              = 1'b0;
         bus.bram_dout_valid = 1'b0;
         txq.delete();
         #1;
         check_output("mid_rst_ready", 32'(bus.s_wready), 32'd0);
         check_chunk("mid_rst_bram_din", bus.bram_din, '0);
         check_output("mid_rst_din_valid", 32'(bus.bram_din_valid), 32'd0);
         check_output("mid_rst_m_rvalid", 32'(bus.m_rvalid), 32'd0);
         check_output("mid_rst_m_rdata", bus.m_rdata, 32'd0);
         check_output("mid_rst_read", 32'(bus.bram_dout_read), 32'd0);
         step();
         resetn = 1'b1;
         step();
         step();
         step();
         check_output("post_rst_no_capture", 32'(bus.m_rvalid), 32'd0);
         apply_rx(32'h0BAD_F00D, 32'h3, 1'b0);
         apply_tx(32'h0000_0201, -1, 0, 1'b0);
      end

      step();
      check_output("end_rx_queue_empty", 32'(rxq.size()), 32'd0);
      check_output("end_tx_queue_empty", 32'(txq.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_bram_word_bridge

// File: doc/bram_word_bridge.md
# bram_word_bridge

Width-conversion stage between the 32-bit DMA/ARM word stream and the 1024-bit chunk ports of the Montgomery command wrapper. The RX path packs 32 consecutive input words into one chunk and presents it on `bram_din`/`bram_din_valid`. The TX path captures a chunk offered on `bram_dout`/`bram_dout_valid`, streams it out as 32 words, then acknowledges it with `bram_dout_read`.

## Interface
- `RSA_BITS`, 1024, chunk width.
- `WORD_BITS`, 32, stream word width; `RSA_BITS` must be an exact multiple.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `s_wdata`  in  WORD_BITS  upstream word.
- `s_wvalid`  in  1  upstream word valid.
- `s_wready`  out  1  bridge accepts upstream word.
- `bram_din`  out  RSA_BITS  packed chunk to the wrapper.
- `bram_din_valid`  out  1  one-cycle pulse: chunk complete.
- `bram_dout`  in  RSA_BITS  result chunk from the wrapper.
- `bram_dout_valid`  in  1  wrapper offers a chunk (level).
- `bram_dout_read`  out  1  one-cycle pulse: chunk fully consumed.
- `m_rdata`  out  WORD_BITS  downstream word.
- `m_rvalid`  out  1  downstream word valid.
- `m_rready`  in  1  downstream accepts word.

## Operation
- Define WORDS = RSA_BITS/WORD_BITS (32). Word index k maps to chunk bits [k*WORD_BITS +: WORD_BITS]. Word 0 is the least-significant word in both directions.
- RX path:
  - `s_wready` = 1 whenever out of reset.
  - A word is accepted on `s_wvalid & s_wready`. It is written into slice `rx_idx` of `bram_din`, and `rx_idx` increments.
  - On acceptance with `rx_idx == WORDS-1`: `rx_idx` wraps to 0 and `bram_din_valid` pulses high on the next cycle.
  - `bram_din` keeps its complete contents until word 0 of the next chunk is accepted. Slices not yet overwritten keep their previous-chunk values.
- TX path FSM states: TX_IDLE, TX_SEND, TX_ACK, TX_WAIT_LOW.
  - TX_IDLE: on `bram_dout_valid`, capture `bram_dout` into a shift register, set `tx_idx` to 0, and go to TX_SEND.
  - TX_SEND: `m_rvalid` = 1 and `m_rdata` = low word of the shift register.
    - On `m_rready`, shift the register right by WORD_BITS and increment `tx_idx`.
    - On handshake with `tx_idx == WORDS-1`, go to TX_ACK.
  - TX_ACK: `m_rvalid` = 0 and `bram_dout_read` = 1 for exactly this one cycle; go to TX_WAIT_LOW.
  - TX_WAIT_LOW: stay until `bram_dout_valid` = 0, then go to TX_IDLE. This exists because the wrapper's valid deasserts registered, one cycle after it sees the read pulse; without it the same chunk would be re-captured.
- RX and TX paths are independent and may be active in the same cycle.

## Timing
- Reset: all outputs are 0, `bram_din` = 0, `rx_idx` = 0, `tx_idx` = 0, FSM in TX_IDLE. Assertion of `resetn` mid-chunk discards partial RX and TX progress immediately; no `bram_din_valid` or `bram_dout_read` pulse is produced for that chunk.
- `s_wready` rises the first cycle after `resetn` deasserts.
- RX latency: `bram_din_valid` is high the cycle after the 32nd word handshake, and `bram_din` already holds the full chunk in that cycle.
  - Back-to-back chunks at 1 word/cycle give one pulse every 32 cycles.
  - A word accepted in the pulse cycle is word 0 of the next chunk. It overwrites slice 0 at the end of that cycle, so the wrapper must sample `bram_din` in the pulse cycle.
- TX latency:
  - First `m_rvalid` appears one cycle after `bram_dout_valid` is sampled in TX_IDLE.
  - With `m_rready` held high: 32 words in 32 cycles, then the `bram_dout_read` pulse in the following cycle.
- TX stall rule: while `m_rvalid` = 1 and `m_rready` = 0, `m_rdata` is held stable.
- `bram_dout` is sampled only in the TX_IDLE capture cycle; later changes to it are ignored.
- `bram_dout_valid` dropping during TX_SEND is ignored; the chunk still completes and is acknowledged.

## Structure
- Shared package `rsa_pkg`: RSA_BITS, WORD_BITS, WORDS, the index width ($clog2(WORDS)), and the TX state encoding.
- One sub-module is natural: `word_unpacker`, the TX FSM plus shift register. The RX packer stays inline.

## Test plan
- Reset then RX: send words 0x00000000..0x0000001F at 1/cycle -> single `bram_din_valid` pulse 1 cycle after the last word; `bram_din[31:0]` = 0, `bram_din[1023:992]` = 0x1F.
- RX with gaps: same 32 words, `s_wvalid` toggling 1-0 -> identical chunk; pulse only after the 32nd handshake; no early pulse.
- TX: `bram_dout` = {32{0xA5A5A5A5}} XOR index pattern, `bram_dout_valid` held until 1 cycle after `bram_dout_read`, `m_rready` = 1 -> 32 words in index order; exactly one `bram_dout_read` pulse; no second capture.
- TX backpressure: `m_rready` low for 5 cycles at word 7 -> `m_rdata` stable at word 7 throughout; total word count is still 32.
- Concurrent: run an RX chunk and a TX chunk in the same cycles -> both complete with correct data and one pulse each.
- Reset mid-operation: `resetn` low after RX word 10 and TX word 10 -> all outputs 0 immediately. A fresh 32-word RX chunk afterwards gives a correct pulse; TX recaptures only once `bram_dout_valid` is asserted again.
